// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM states and
// request legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LD_RD  = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WR     = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (funct3)
            F3_H, F3_HU: mis = lo[0];
            F3_W:        mis = (lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        logic bad;
        if (we) begin
            bad = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        end else begin
            bad = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: load extraction/extension and sub-word store
// merge into a full memory word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[7:0];
        case (byte_off)
            2'd0: lane_b = rdata[7:0];
            2'd1: lane_b = rdata[15:8];
            2'd2: lane_b = rdata[23:16];
            2'd3: lane_b = rdata[31:24];
            default: lane_b = rdata[7:0];
        endcase
        lane_h = byte_off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Unknown width codes only reach here when alignment checking is off;
    // they fall back to a full-word access.
    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_data = {24'h0, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_data = {16'h0, lane_h};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        store_word = wdata;
        case (funct3[1:0])
            2'b00: begin
                store_word = rdata;
                case (byte_off)
                    2'd0: store_word[7:0]   = wdata[7:0];
                    2'd1: store_word[15:8]  = wdata[7:0];
                    2'd2: store_word[23:16] = wdata[7:0];
                    2'd3: store_word[31:24] = wdata[7:0];
                    default: store_word[7:0] = wdata[7:0];
                endcase
            end
            2'b01: begin
                store_word = rdata;
                if (byte_off[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a word-wide data memory;
// sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              we_q, we_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0] load_data;
    logic [31:0] merged_word;
    logic        req_bad;

    lsu_align u_align (
        .funct3     (funct3_q),
        .byte_off   (addr_q[1:0]),
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (merged_word)
    );

    assign req_bad = CHECK_ALIGN &&
                     (is_illegal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    we_d     = req_we;
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    if (req_bad) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (!req_we) begin
                        state_d = ST_LD_RD;
                    end else if (req_funct3[1]) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LD_RD: begin
                rdata_d = load_data;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                // The merged word replaces the store data so WR always drives wdata_q.
                wdata_d = merged_word;
                state_d = ST_WR;
            end
            ST_WR: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid & err_q;

    // Strobes come from the state register alone so they are glitch-free.
    assign mem_read  = (state_q == ST_LD_RD) || (state_q == ST_RMW_RD);
    assign mem_write = (state_q == ST_WR) && we_q;
    assign mem_addr  = (mem_read || mem_write) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata = mem_write ? wdata_q : '0;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
CPU-side initiator for the word-organised data memory. It accepts one load/store request at a time from the execute stage and drives the memory's read/write strobes, word address and write data. It also performs byte and halfword extraction with sign or zero extension. Sub-word stores are done as a read-modify-write, because the memory only writes full words.

Parameters:
ADDR_W, 32, width of byte address on request and memory sides
CHECK_ALIGN, 1, 1 = misaligned or illegal requests return resp_err and never touch memory; 0 = low address bits are ignored for alignment

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  LSU can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  load result, extended; 0 for stores and errors
resp_err  out  1  misaligned or illegal funct3
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe; memory writes on the rising clk edge
mem_addr  out  ADDR_W  byte address to memory, low 2 bits forced to 00
mem_wdata  out  32  full word to write
mem_rdata  in  32  combinational read data, valid in the same cycle as mem_read

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- FSM states: IDLE, LD_RD, RMW_RD, WR, RESP.
- Reset: state goes to IDLE immediately on rst_n low. All outputs are 0 except req_ready, which is 1. Latched request registers clear to 0.
- A reset during any state, including WR, drops mem_write in the same cycle. No partial write is required afterwards.
- Memory strobes are decoded from the state only, with no dependence on req_* inputs, so the memory sees glitch-free one-cycle strobes.
- IDLE: req_ready=1. On the rising edge with req_valid=1, latch addr, wdata, funct3 and we, then go to:
  - RESP with err=1, if the request is illegal or misaligned and CHECK_ALIGN=1.
    - Illegal funct3: 011, 110, 111 for loads; anything but 000/001/010 for stores.
    - Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=00.
  - LD_RD, for a load.
  - WR, for a store word.
  - RMW_RD, for a store byte or store halfword.
- LD_RD: mem_read=1, mem_addr={addr[ADDR_W-1:2],2'b00}.
  - Select the lane by addr[1:0] (byte) or addr[1] (half).
  - Sign-extend for B/H; zero-extend for BU/HU.
  - Register the result into resp_rdata, then go to RESP.
- RMW_RD: mem_read=1. Merge the latched data into mem_rdata:
  - byte → lane addr[1:0];
  - half → bits [15:0] or [31:16] by addr[1].
  - Register the merged word, then go to WR.
- WR: mem_write=1. mem_wdata = full wdata or the merged word. Go to RESP.
- RESP: resp_valid=1 and resp_rdata/resp_err stable. Hold until resp_ready=1; on that edge go to IDLE.
  - A new request is not accepted in the same cycle; req_ready rises the cycle after the handshake.
- Latency from request acceptance edge to first resp_valid cycle:
  - error: 1;
  - load: 2;
  - store word: 2;
  - sub-word store: 3.
- Throughput with resp_ready tied high: one load per 3 cycles.
- mem_addr and mem_wdata are 0 when their strobe is low.

Decomposition:
- Shared package lsu_pkg:
  - funct3 width constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the FSM state enum;
  - function is_misaligned(funct3, addr[1:0]).
- One sub-module, lsu_align: purely combinational, containing:
  - load lane extraction and extension;
  - store lane merge.
- The FSM and registers stay in load_store_unit.

Test Plan:
- SW 0x10 data 0x8899AABB, then LW 0x10 → write seen once in WR; resp_rdata=0x8899AABB, resp_err=0, load response 2 cycles after acceptance.
- With word 0x10=0x8899AABB:
  - LB 0x13 → 0xFFFFFF88;
  - LBU 0x12 → 0x00000099;
  - LH 0x12 → 0xFFFF8899;
  - LHU 0x10 → 0x0000AABB.
- SB 0x11 data 0xFFFFFF5A → one mem_read cycle then one mem_write cycle with mem_wdata=0x88995ABB; a later LW 0x10 returns 0x88995ABB.
- LW 0x12 and SH 0x13 → resp_err=1, resp_rdata=0, resp_valid one cycle after acceptance; mem_read and mem_write never assert.
- Backpressure: load issued with resp_ready held low 4 cycles → resp_valid and data stable throughout, req_ready=0; IDLE is re-entered the cycle after resp_ready=1.
- Assert rst_n low during WR of an SH → mem_write drops in the same cycle; req_ready=1 and resp_valid=0 after release; the next LW works normally.
